// File: rtl/risco5_bus_pkg.sv
// Shared bus definitions: arbiter state encoding and master identifiers.
// Future bus typedefs belong here as well.
package risco5_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } arb_state_t;

    localparam logic MASTER0 = 1'b0;
    localparam logic MASTER1 = 1'b1;

endpackage

// File: rtl/memory_arbiter.sv
// Two-master arbiter in front of a single memory port with registered mem_* outputs.
// Define ARB_ROUND_ROBIN_EN for round-robin on conflict; otherwise master 0 has fixed priority.
module memory_arbiter
    import risco5_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_ack,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_ack,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack
);

    arb_state_t            state;
    arb_state_t            state_next;
    logic                  grant_valid;
    logic                  grant_sel;
    logic [DATA_WIDTH-1:0] rdata_q;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_winner;
`endif

    always_comb begin : grant_decision
        grant_valid = m0_req | m1_req;
        grant_sel   = MASTER0;
        if (m0_req && m1_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            grant_sel = ~last_winner;
`else
            grant_sel = MASTER0;
`endif
        end else begin
            grant_sel = m1_req;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Acks are masked during reset so an abandoned access never completes.
    always_comb begin
        state_next = state;
        m0_ack     = 1'b0;
        m1_ack     = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid) state_next = grant_sel ? BUSY1 : BUSY0;
            end
            BUSY0: begin
                if (mem_ack) begin
                    m0_ack     = ~reset;
                    state_next = IDLE;
                end
            end
            BUSY1: begin
                if (mem_ack) begin
                    m1_ack     = ~reset;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign rdata = (m0_ack | m1_ack) ? mem_rdata : rdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_winner <= MASTER1;
`endif
        end else if (state == IDLE && grant_valid) begin
            mem_req   <= 1'b1;
            mem_we    <= grant_sel ? m1_we    : m0_we;
            mem_addr  <= grant_sel ? m1_addr  : m0_addr;
            mem_wdata <= grant_sel ? m1_wdata : m0_wdata;
`ifdef ARB_ROUND_ROBIN_EN
            last_winner <= grant_sel;
`endif
        end else if (m0_ack || m1_ack) begin
            mem_req <= 1'b0;
            rdata_q <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios plus randomized traffic
// checked cycle by cycle against a transaction-level reference model.
module tb_memory_arbiter;
    import risco5_bus_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic        m0_ack, m1_ack, mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    always #5 clk = ~clk;

    memory_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ack(m1_ack),
        .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    int checks = 0, failures = 0, cyc = 0;
    // memory slave
    int mem_lat = 1, mem_cnt = 0;
    bit spur_ack = 0, rd_force = 0;
    logic [31:0] rd_val = '0;
    // masters
    bit persist = 0, rand_mode = 0, ack0_seen = 0, ack1_seen = 0;
    // reference model
    bit model_valid = 0, m_busy = 0;
    int m_win = 0, m_last = 1;
    logic m_we = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0, exp_rdata = '0;
    // observation log
    int ack0_cnt = 0, ack1_cnt = 0, ack0_cyc = 0, ack1_cyc = 0;
    logic [31:0] ack_rdata = '0;
    int ack_log[$];

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        ack0_cnt = 0; ack1_cnt = 0; ack0_cyc = 0; ack1_cyc = 0;
        ack_log.delete();
    endtask

    // Rising edge + 1: memory slave responds, masters react to acks seen last cycle.
    task automatic step_begin();
        @(posedge clk);
        #1;
        cyc++;
        if (spur_ack) begin
            mem_ack = 1'b1; mem_rdata = $urandom; spur_ack = 0;
        end else if (mem_req === 1'b1) begin
            if (mem_cnt >= mem_lat) begin
                mem_ack = 1'b1;
                mem_rdata = rd_force ? rd_val : $urandom;
                mem_cnt = 0;
                if (rand_mode) mem_lat = $urandom_range(1, 4);
            end else begin
                mem_ack = 1'b0; mem_rdata = $urandom; mem_cnt++;
            end
        end else begin
            mem_ack = 1'b0; mem_rdata = $urandom; mem_cnt = 0;
        end
        if (ack0_seen) begin
            ack0_seen = 0;
            if (persist) begin
                m0_we = 1'($urandom); m0_addr = $urandom; m0_wdata = $urandom;
            end else m0_req = 1'b0;
        end else if (rand_mode && !m0_req && $urandom_range(0, 2) == 0) begin
            m0_req = 1'b1; m0_we = 1'($urandom); m0_addr = $urandom; m0_wdata = $urandom;
        end
        if (ack1_seen) begin
            ack1_seen = 0;
            if (persist) begin
                m1_we = 1'($urandom); m1_addr = $urandom; m1_wdata = $urandom;
            end else m1_req = 1'b0;
        end else if (rand_mode && !m1_req && $urandom_range(0, 2) == 0) begin
            m1_req = 1'b1; m1_we = 1'($urandom); m1_addr = $urandom; m1_wdata = $urandom;
        end
    endtask

    // Falling edge: compare against the model, then advance the model to the next edge.
    task automatic step_end();
        bit e0, e1;
        @(negedge clk);
        if (reset) begin
            check("ack0_in_reset", 32'(m0_ack), 0);
            check("ack1_in_reset", 32'(m1_ack), 0);
            m_busy = 0; m_we = 1'b0; m_addr = '0; m_wdata = '0; exp_rdata = '0; m_last = 1;
            model_valid = 1;
        end else if (model_valid) begin
            check("mdl_mem_req", 32'(mem_req), 32'(m_busy));
            check("mdl_mem_we", 32'(mem_we), 32'(m_we));
            check("mdl_mem_addr", mem_addr, m_addr);
            check("mdl_mem_wdata", mem_wdata, m_wdata);
            e0 = m_busy && mem_ack && (m_win == 0);
            e1 = m_busy && mem_ack && (m_win == 1);
            check("mdl_m0_ack", 32'(m0_ack), 32'(e0));
            check("mdl_m1_ack", 32'(m1_ack), 32'(e1));
            if (m_busy && mem_ack) exp_rdata = mem_rdata;
            check("mdl_rdata", rdata, exp_rdata);
            if (m_busy && mem_ack) begin
                m_busy = 0;
            end else if (!m_busy && (m0_req || m1_req)) begin
                if (m0_req && m1_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                    m_win = 1 - m_last;
`else
                    m_win = 0;
`endif
                end else m_win = m1_req ? 1 : 0;
                m_last  = m_win;
                m_we    = (m_win == 1) ? m1_we : m0_we;
                m_addr  = (m_win == 1) ? m1_addr : m0_addr;
                m_wdata = (m_win == 1) ? m1_wdata : m0_wdata;
                m_busy  = 1;
            end
        end
        if (m0_ack === 1'b1) begin ack0_cnt++; ack0_cyc = cyc; ack_rdata = rdata; ack_log.push_back(0); end
        if (m1_ack === 1'b1) begin ack1_cnt++; ack1_cyc = cyc; ack_rdata = rdata; ack_log.push_back(1); end
        ack0_seen = (m0_ack === 1'b1);
        ack1_seen = (m1_ack === 1'b1);
    endtask

    task automatic cycle();
        step_begin();
        step_end();
    endtask

    initial begin
        int t0, stable;
        int exp_order[4];
        logic [31:0] r_before;

        cycle(); cycle();
        step_begin(); reset = 1'b0; step_end();
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_rdata", rdata, 0);

        // m0 read, 1-cycle memory
        clear_log(); mem_lat = 1; rd_force = 1; rd_val = 32'hDEADBEEF;
        step_begin(); m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10; m0_wdata = $urandom; t0 = cyc; step_end();
        for (int i = 0; i < 20 && ack0_cnt == 0; i++) cycle();
        check("rd_ack0_count", 32'(ack0_cnt), 1);
        check("rd_latency", 32'(ack0_cyc - t0), 2);
        check("rd_rdata", ack_rdata, 32'hDEADBEEF);
        check("rd_ack1_none", 32'(ack1_cnt), 0);
        cycle(); cycle();
        check("rd_rdata_hold", rdata, 32'hDEADBEEF);
        rd_force = 0;

        // m1 write, 4-cycle memory, m1 inputs wiggle while busy
        clear_log(); mem_lat = 4; stable = 0;
        step_begin(); m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h55; t0 = cyc; step_end();
        for (int i = 0; i < 20 && ack1_cnt == 0; i++) begin
            step_begin();
            if (i == 1) begin m1_addr = 32'h99; m1_wdata = 32'hAA; m1_we = 1'b0; end
            step_end();
            if (mem_req === 1'b1 && mem_we === 1'b1 && mem_addr === 32'h20 && mem_wdata === 32'h55) stable++;
        end
        check("wr_stable_cycles", 32'(stable), 5);
        check("wr_latency", 32'(ack1_cyc - t0), 5);
        cycle(); cycle(); cycle();
        check("wr_ack1_single", 32'(ack1_cnt), 1);
        check("wr_ack0_none", 32'(ack0_cnt), 0);

        // spurious mem_ack while idle
        clear_log(); r_before = rdata; spur_ack = 1;
        cycle();
        check("spur_m0_ack", 32'(m0_ack), 0);
        check("spur_m1_ack", 32'(m1_ack), 0);
        check("spur_rdata", rdata, r_before);
        cycle();
        check("spur_rdata_after", rdata, r_before);

        // randomized traffic
        rand_mode = 1;
        for (int i = 0; i < 800; i++) cycle();
        rand_mode = 0;
        for (int i = 0; i < 100 && (m0_req || m1_req || m_busy); i++) cycle();
        check("rand_drained", 32'(m0_req || m1_req || m_busy), 0);

        // both masters requesting continuously right after reset
        step_begin(); reset = 1'b1; step_end();
        clear_log(); mem_lat = 1; persist = 1;
        step_begin(); reset = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = $urandom; m0_wdata = $urandom;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = $urandom; m1_wdata = $urandom;
        step_end();
        for (int i = 0; i < 16; i++) cycle();
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0};
        check("fixed_m1_starved", 32'(ack1_cnt), 0);
`endif
        for (int i = 0; i < 4; i++)
            check($sformatf("grant_order_%0d", i), (i < ack_log.size()) ? 32'(ack_log[i]) : 32'd99, 32'(exp_order[i]));
        persist = 0;
        for (int i = 0; i < 50 && (m0_req || m1_req || m_busy); i++) cycle();
        check("order_drained", 32'(m0_req || m1_req || m_busy), 0);

        // reset while BUSY0, late mem_ack afterwards
        clear_log(); mem_lat = 5;
        step_begin(); m0_req = 1'b1; m0_we = 1'b0; m0_addr = $urandom; step_end();
        cycle();
        check("rstbusy_state_busy0", 32'(dut.state), 32'(BUSY0));
        step_begin(); reset = 1'b1; m0_req = 1'b0; spur_ack = 1; step_end();
        step_begin(); reset = 1'b0; step_end();
        check("rstbusy_m0_ack", 32'(m0_ack), 0);
        check("rstbusy_mem_req", 32'(mem_req), 0);
        check("rstbusy_state_idle", 32'(dut.state), 32'(IDLE));
        cycle(); cycle();
        check("rstbusy_no_ack_total", 32'(ack0_cnt + ack1_cnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
